// File: rtl/msk_hpc3_rnd_source_pkg.sv
// rtl/msk_hpc3_rnd_source_pkg.sv - shared constants and helpers for the HPC3 randomness source
// Purpose: FSM encoding, LFSR tap positions, zero-seed fallback and the
// per-gadget fresh-randomness width function shared with the gadget family.
package msk_hpc3_rnd_source_pkg;

  localparam logic [1:0] ST_UNSEEDED = 2'd0;
  localparam logic [1:0] ST_WARMUP   = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  // Fibonacci taps 64,63,61,60 expressed as 0-based bit indices.
  localparam int LFSR_TAP0 = 63;
  localparam int LFSR_TAP1 = 62;
  localparam int LFSR_TAP2 = 60;
  localparam int LFSR_TAP3 = 59;

  // An all-zero LFSR state is a fixed point, so a zero seed is replaced.
  localparam logic [63:0] SEED_FALLBACK_DEF = 64'hACE1_ACE1_ACE1_ACE1;

  // Fresh bits one HPC3 gadget consumes per cycle (rnd0 and rnd1 halves).
  function automatic int hpc3rnd(input int shares);
    return shares * (shares - 1);
  endfunction

endpackage

// File: rtl/msk_lfsr64_unroll.sv
// rtl/msk_lfsr64_unroll.sv - combinational STEPS-fold unroll of the 64-bit Fibonacci LFSR
// Purpose: advances the LFSR STEPS times in one cycle.
// Ports:
//   state_i  current 64-bit state
//   state_o  state after STEPS steps
//   bits_o   feedback bit of step i in bit i (step 0 first)
module msk_lfsr64_unroll
  import msk_hpc3_rnd_source_pkg::*;
#(
  parameter int STEPS = 2
) (
  input  logic [63:0]      state_i,
  output logic [63:0]      state_o,
  output logic [STEPS-1:0] bits_o
);

  logic [63:0] walk;

  always_comb begin
    walk   = state_i;
    bits_o = '0;
    for (int i = 0; i < STEPS; i++) begin
      bits_o[i] = walk[LFSR_TAP0] ^ walk[LFSR_TAP1] ^ walk[LFSR_TAP2] ^ walk[LFSR_TAP3];
      walk      = {walk[62:0], bits_o[i]};
    end
    state_o = walk;
  end

endmodule

// File: rtl/msk_hpc3_rnd_source.sv
// rtl/msk_hpc3_rnd_source.sv - seeded fresh-randomness streamer for NGADGETS parallel HPC3 gadgets
// Purpose: accepts a 64-bit seed, warms the LFSR up for WARMUP_CYC cycles,
// then streams RND_W-bit words on a valid/ready output.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   seed_valid/ready/data     seed handshake (accepted in UNSEEDED and RUN)
//   rnd_valid/ready/out       randomness word stream, rnd_out is a register
//   word_cnt                  words consumed since last seed, saturating
module msk_hpc3_rnd_source
  import msk_hpc3_rnd_source_pkg::*;
#(
  parameter int          d             = 2,
  parameter int          NGADGETS      = 1,
  parameter int          WARMUP_CYC    = 16,
  parameter logic [63:0] SEED_FALLBACK = SEED_FALLBACK_DEF,
  localparam int         RND_W         = NGADGETS * hpc3rnd(d)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [63:0]      seed_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [RND_W-1:0] rnd_out,
  output logic [31:0]      word_cnt
);

  logic [1:0]       fsm_q, fsm_d;
  logic [63:0]      lfsr_q, lfsr_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [31:0]      warm_q, warm_d;

  logic [63:0]      lfsr_nxt;
  logic [RND_W-1:0] lfsr_bits;
  logic             seed_hs;
  logic             out_hs;

  msk_lfsr64_unroll #(.STEPS(RND_W)) u_unroll (
    .state_i (lfsr_q),
    .state_o (lfsr_nxt),
    .bits_o  (lfsr_bits)
  );

  assign seed_ready = (fsm_q != ST_WARMUP);
  assign seed_hs    = seed_valid & seed_ready;
  assign out_hs     = valid_q & rnd_ready;

  assign rnd_valid  = valid_q;
  assign rnd_out    = rnd_q;
  assign word_cnt   = word_cnt_q;

  always_comb begin
    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    rnd_d      = rnd_q;
    valid_d    = valid_q;
    word_cnt_d = word_cnt_q;
    warm_d     = warm_q;

    // A seed handshake restarts the stream and takes priority over a
    // concurrent output handshake, whose word is then not counted.
    if (seed_hs) begin
      lfsr_d     = (seed_data == 64'd0) ? SEED_FALLBACK : seed_data;
      warm_d     = 32'(WARMUP_CYC - 1);
      valid_d    = 1'b0;
      word_cnt_d = 32'd0;
      fsm_d      = ST_WARMUP;
    end else begin
      case (fsm_q)
        ST_WARMUP: begin
          lfsr_d = lfsr_nxt;
          if (warm_q == 32'd0) begin
            rnd_d   = lfsr_bits;
            valid_d = 1'b1;
            fsm_d   = ST_RUN;
          end else begin
            warm_d = warm_q - 32'd1;
          end
        end
        ST_RUN: begin
          if (out_hs) begin
            lfsr_d = lfsr_nxt;
            rnd_d  = lfsr_bits;
            if (word_cnt_q != 32'hFFFF_FFFF) word_cnt_d = word_cnt_q + 32'd1;
          end
        end
        ST_UNSEEDED: ;
        default: fsm_d = ST_UNSEEDED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= ST_UNSEEDED;
      lfsr_q     <= 64'd0;
      rnd_q      <= '0;
      valid_q    <= 1'b0;
      word_cnt_q <= 32'd0;
      warm_q     <= 32'd0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      rnd_q      <= rnd_d;
      valid_q    <= valid_d;
      word_cnt_q <= word_cnt_d;
      warm_q     <= warm_d;
    end
  end

endmodule

// File: tb/tb_msk_hpc3_rnd_source.sv
// tb/tb_msk_hpc3_rnd_source.sv - scoreboard bench for msk_hpc3_rnd_source (d=2/NG=1 and d=3/NG=2)
module tb_msk_hpc3_rnd_source;

  localparam logic [63:0] FALLBACK = 64'hACE1_ACE1_ACE1_ACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        seed_valid_a, seed_ready_a, rnd_valid_a, rnd_ready_a;
  logic [63:0] seed_data_a;
  logic [1:0]  rnd_out_a;
  logic [31:0] word_cnt_a;

  logic        seed_valid_b, seed_ready_b, rnd_valid_b, rnd_ready_b;
  logic [63:0] seed_data_b;
  logic [11:0] rnd_out_b;
  logic [31:0] word_cnt_b;

  msk_hpc3_rnd_source #(.d(2), .NGADGETS(1), .WARMUP_CYC(16)) dut_a (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid_a), .seed_ready(seed_ready_a), .seed_data(seed_data_a),
    .rnd_valid(rnd_valid_a), .rnd_ready(rnd_ready_a), .rnd_out(rnd_out_a),
    .word_cnt(word_cnt_a)
  );

  msk_hpc3_rnd_source #(.d(3), .NGADGETS(2), .WARMUP_CYC(16)) dut_b (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid_b), .seed_ready(seed_ready_b), .seed_data(seed_data_b),
    .rnd_valid(rnd_valid_b), .rnd_ready(rnd_ready_b), .rnd_out(rnd_out_b),
    .word_cnt(word_cnt_b)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ms_a, pend_a, ms_b, pend_b;
  logic [31:0] cnt_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Bit-serial reference LFSR: bit i of the word is the feedback of step i.
  task automatic adv(input int w, inout logic [63:0] s, output logic [63:0] wd);
    logic fb;
    wd = '0;
    for (int i = 0; i < w; i++) begin
      fb    = s[63] ^ s[62] ^ s[60] ^ s[59];
      wd[i] = fb;
      s     = {s[62:0], fb};
    end
  endtask

  task automatic seed_a(input logic [63:0] sd, input logic rdy);
    chk("a_seed_ready_before_seed", {63'd0, seed_ready_a}, 64'd1);
    seed_valid_a = 1'b1;
    seed_data_a  = sd;
    rnd_ready_a  = rdy;
    @(posedge clk); #1;
    seed_valid_a = 1'b0;
    rnd_ready_a  = 1'b0;
    ms_a = (sd == 64'd0) ? FALLBACK : sd;
    for (int i = 0; i < 16; i++) adv(2, ms_a, pend_a);
    cnt_a = 32'd0;
    chk("a_word_cnt_after_seed", {32'd0, word_cnt_a}, 64'd0);
    chk("a_valid_after_seed", {63'd0, rnd_valid_a}, 64'd0);
  endtask

  task automatic wait_valid_a(input string nm);
    int k;
    k = 0;
    while (!rnd_valid_a && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, 64'(k), 64'd16);
  endtask

  task automatic consume_a(input int n);
    for (int i = 0; i < n; i++) begin
      qa.push_back(pend_a);
      adv(2, ms_a, pend_a);
    end
    rnd_ready_a = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rnd_ready_a = 1'b0;
    cnt_a = cnt_a + 32'(n);
    chk("a_word_cnt", {32'd0, word_cnt_a}, {32'd0, cnt_a});
  endtask

  // Monitor: a word is consumed on valid & ready unless a seed handshake
  // in the same cycle takes precedence.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rnd_valid_a && rnd_ready_a && !(seed_valid_a && seed_ready_a)) begin
        if (qa.size() == 0) chk("a_unexpected_word", {62'd0, rnd_out_a}, 64'hX);
        else begin
          e = qa.pop_front();
          chk("a_rnd_out", {62'd0, rnd_out_a}, e);
        end
      end
      if (!rst && rnd_valid_b && rnd_ready_b && !(seed_valid_b && seed_ready_b)) begin
        if (qb.size() == 0) chk("b_unexpected_word", {52'd0, rnd_out_b}, 64'hX);
        else begin
          e = qb.pop_front();
          chk("b_rnd_out", {52'd0, rnd_out_b}, e);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    seed_valid_a = 1'b0; seed_data_a = '0; rnd_ready_a = 1'b0;
    seed_valid_b = 1'b0; seed_data_b = '0; rnd_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    chk("a_rst_valid", {63'd0, rnd_valid_a}, 64'd0);
    chk("a_rst_out", {62'd0, rnd_out_a}, 64'd0);
    chk("a_rst_cnt", {32'd0, word_cnt_a}, 64'd0);
    chk("a_rst_seed_ready", {63'd0, seed_ready_a}, 64'd1);
    chk("a_rst_fsm", {62'd0, dut_a.fsm_q}, 64'd0);
    chk("b_rst_valid", {63'd0, rnd_valid_b}, 64'd0);
    chk("b_rst_seed_ready", {63'd0, seed_ready_b}, 64'd1);

    // Seed 1: latency and first 8 words (seed 1 gives 0 until step 59)
    seed_a(64'h1, 1'b1);
    wait_valid_a("a_latency_seed1");
    chk("a_warmup_seed_ready", {63'd0, seed_ready_a}, 64'd1);
    consume_a(8);

    // Zero seed falls back to the constant; compare with explicit constant run
    seed_a(64'h0, 1'b0);
    chk("a_zero_seed_state", dut_a.lfsr_q, FALLBACK);
    wait_valid_a("a_latency_seed0");
    consume_a(8);
    seed_a(FALLBACK, 1'b0);
    wait_valid_a("a_latency_fallback_const");
    consume_a(8);

    // Backpressure: word and count hold, no skipped word afterwards
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("a_hold_out", {62'd0, rnd_out_a}, pend_a);
      chk("a_hold_cnt", {32'd0, word_cnt_a}, {32'd0, cnt_a});
    end
    consume_a(3);

    // Reseed in RUN together with an output handshake
    seed_a(64'h0123_4567_89AB_CDEF, 1'b1);
    wait_valid_a("a_latency_reseed");
    consume_a(10);

    // rst during warm-up with a seed offered in the same cycle
    seed_a(64'h5A5A_F00D_1234_9876, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1; seed_valid_a = 1'b1; seed_data_a = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    rst = 1'b0; seed_valid_a = 1'b0;
    chk("a_midrst_valid", {63'd0, rnd_valid_a}, 64'd0);
    chk("a_midrst_out", {62'd0, rnd_out_a}, 64'd0);
    chk("a_midrst_cnt", {32'd0, word_cnt_a}, 64'd0);
    chk("a_midrst_seed_ready", {63'd0, seed_ready_a}, 64'd1);
    chk("a_midrst_fsm", {62'd0, dut_a.fsm_q}, 64'd0);
    chk("a_midrst_state", dut_a.lfsr_q, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("a_midrst_still_idle", {63'd0, rnd_valid_a}, 64'd0);

    // Wide instance: 100 words, then counter saturation
    seed_valid_b = 1'b1;
    seed_data_b  = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    seed_valid_b = 1'b0;
    ms_b = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 16; i++) adv(12, ms_b, pend_b);
    k = 0;
    while (!rnd_valid_b && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b_latency", 64'(k), 64'd16);
    for (int i = 0; i < 100; i++) begin
      qb.push_back(pend_b);
      adv(12, ms_b, pend_b);
    end
    rnd_ready_b = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rnd_ready_b = 1'b0;
    chk("b_word_cnt_100", {32'd0, word_cnt_b}, 64'd100);

    force dut_b.word_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut_b.word_cnt_q;
    chk("b_word_cnt_preset", {32'd0, word_cnt_b}, 64'h0000_0000_FFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      qb.push_back(pend_b);
      adv(12, ms_b, pend_b);
    end
    rnd_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rnd_ready_b = 1'b0;
    chk("b_word_cnt_sat", {32'd0, word_cnt_b}, 64'h0000_0000_FFFF_FFFF);

    @(posedge clk); #1;
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
